// File: rtl/rom_loader_pkg.sv
// Shared FSM encoding and default fill byte for the ROM image loader.
package rom_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RECV  = 3'd1,
      ST_WRITE = 3'd2,
      ST_PAD   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [7:0] PAD_BYTE = 8'hFF;

endpackage

// File: rtl/rom_loader_wr.sv
// Single-entry write port: holds address/data stable and keeps mem_req up
// until the memory acknowledges. Shared by the receive and pad paths.
module rom_loader_wr #(
   parameter int AW = 15
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          load_i,
   input  logic [AW-1:0] addr_i,
   input  logic [7:0]    data_i,
   input  logic          mem_ack_i,
   output logic          mem_req_o,
   output logic [AW-1:0] mem_address_o,
   output logic [7:0]    mem_d_o,
   output logic          done_o
);

   logic          req_q, req_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [7:0]    data_q, data_d;

   // load_i is only raised by the controller while no request is outstanding
   always_comb begin
      req_d  = req_q;
      addr_d = addr_q;
      data_d = data_q;
      if (load_i) begin
         req_d  = 1'b1;
         addr_d = addr_i;
         data_d = data_i;
      end else if (req_q && mem_ack_i) begin
         req_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         req_q  <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         req_q  <= req_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end

   assign mem_req_o     = req_q;
   assign mem_address_o = addr_q;
   assign mem_d_o       = data_q;
   assign done_o        = req_q & mem_ack_i;

endmodule

// File: rtl/rom_loader.sv
// Streams download bytes into cartridge ROM RAM, then fills the rest with PAD.
// Define ROM_LOADER_CHECKSUM_EN to build the modulo-256 checksum of written bytes.
module rom_loader
   import rom_loader_pkg::*;
#(
   parameter int         KB  = 32,
   parameter logic [7:0] PAD = PAD_BYTE,
   localparam int        AW  = $clog2(KB * 1024)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          dl_start,
   input  logic          dl_valid,
   input  logic [7:0]    dl_data,
   output logic          dl_ready,
   input  logic          dl_end,
   output logic          mem_req,
   input  logic          mem_ack,
   output logic [AW-1:0] mem_address,
   output logic [7:0]    mem_d,
   output logic          busy,
   output logic          done,
   output logic [AW:0]   size,
   output logic          overflow,
   output logic [7:0]    checksum
);

   localparam int unsigned CAP_I = KB * 1024;
   localparam logic [AW:0] CAP   = CAP_I[AW:0];
   localparam logic [AW:0] ONE   = (AW + 1)'(1);

   state_t      state_q, state_d;
   logic [AW:0] addr_q, addr_d;
   logic [AW:0] size_q, size_d;
   logic        ovf_q, ovf_d;
   logic        end_pend_q, end_pend_d;
   logic        start_pend_q, start_pend_d;
   logic        load;
   logic [7:0]  load_data;
   logic        wr_done;
   logic        restart;
   logic        start_seen;
   logic [AW:0] addr_inc;
`ifdef ROM_LOADER_CHECKSUM_EN
   logic [7:0]  csum_q, csum_d;
`endif

   rom_loader_wr #(.AW(AW)) u_wr (
      .clock         (clock),
      .reset         (reset),
      .load_i        (load),
      .addr_i        (addr_q[AW-1:0]),
      .data_i        (load_data),
      .mem_ack_i     (mem_ack),
      .mem_req_o     (mem_req),
      .mem_address_o (mem_address),
      .mem_d_o       (mem_d),
      .done_o        (wr_done)
   );

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      size_d       = size_q;
      ovf_d        = ovf_q;
      end_pend_d   = end_pend_q;
      start_pend_d = start_pend_q;
`ifdef ROM_LOADER_CHECKSUM_EN
      csum_d       = csum_q;
`endif
      load         = 1'b0;
      load_data    = dl_data;
      restart      = 1'b0;
      addr_inc     = addr_q + ONE;
      start_seen   = start_pend_q | dl_start;

      case (state_q)
         ST_IDLE, ST_DONE: restart = dl_start;
         ST_RECV: begin
            if (dl_start) begin
               restart = 1'b1;
            end else if (dl_valid && (addr_q < CAP)) begin
               load       = 1'b1;
               end_pend_d = dl_end;
               state_d    = ST_WRITE;
            end else begin
               if (dl_valid) ovf_d = 1'b1;
               if (dl_end) state_d = ST_PAD;
            end
         end
         ST_WRITE: begin
            start_pend_d = start_seen;
            end_pend_d   = end_pend_q | dl_end;
            if (wr_done) begin
               addr_d     = addr_inc;
               size_d     = size_q + ONE;
               end_pend_d = 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
               csum_d     = csum_q + mem_d;
`endif
               if (start_seen)                restart = 1'b1;
               else if (end_pend_q || dl_end) state_d = (addr_inc == CAP) ? ST_DONE : ST_PAD;
               else                           state_d = ST_RECV;
            end
         end
         ST_PAD: begin
            // A pending restart waits for the outstanding pad write to be acked
            start_pend_d = start_seen;
            if (mem_req) begin
               if (wr_done) begin
                  addr_d = addr_inc;
                  if (start_seen)            restart = 1'b1;
                  else if (addr_inc == CAP)  state_d = ST_DONE;
               end
            end else if (start_seen) begin
               restart = 1'b1;
            end else if (addr_q == CAP) begin
               state_d = ST_DONE;
            end else begin
               load      = 1'b1;
               load_data = PAD;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (restart) begin
         state_d      = ST_RECV;
         addr_d       = '0;
         size_d       = '0;
         ovf_d        = 1'b0;
         end_pend_d   = 1'b0;
         start_pend_d = 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
         csum_d       = '0;
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         size_q       <= '0;
         ovf_q        <= 1'b0;
         end_pend_q   <= 1'b0;
         start_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         size_q       <= size_d;
         ovf_q        <= ovf_d;
         end_pend_q   <= end_pend_d;
         start_pend_q <= start_pend_d;
      end
   end

`ifdef ROM_LOADER_CHECKSUM_EN
   always_ff @(posedge clock) begin
      if (!reset) csum_q <= '0;
      else        csum_q <= csum_d;
   end
   assign checksum = csum_q;
`else
   assign checksum = 8'h00;
`endif

   assign dl_ready = (state_q == ST_RECV);
   assign busy     = (state_q == ST_RECV) || (state_q == ST_WRITE) || (state_q == ST_PAD);
   assign done     = (state_q == ST_DONE);
   assign size     = size_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader (KB=1): random streams against an image model.
module tb_rom_loader;

   localparam int KB  = 1;
   localparam int AW  = 10;
   localparam int CAP = 1024;

   logic          clock    = 1'b0;
   logic          reset    = 1'b0;
   logic          dl_start = 1'b0;
   logic          dl_valid = 1'b0;
   logic          dl_end   = 1'b0;
   logic          mem_ack  = 1'b0;
   logic [7:0]    dl_data  = 8'h00;
   logic          dl_ready, mem_req, busy, done, overflow;
   logic [AW-1:0] mem_address;
   logic [7:0]    mem_d, checksum;
   logic [AW:0]   size;

   rom_loader #(.KB(KB), .PAD(8'hFF)) dut (
      .clock       (clock),
      .reset       (reset),
      .dl_start    (dl_start),
      .dl_valid    (dl_valid),
      .dl_data     (dl_data),
      .dl_ready    (dl_ready),
      .dl_end      (dl_end),
      .mem_req     (mem_req),
      .mem_ack     (mem_ack),
      .mem_address (mem_address),
      .mem_d       (mem_d),
      .busy        (busy),
      .done        (done),
      .size        (size),
      .overflow    (overflow),
      .checksum    (checksum)
   );

   always #5 clock = ~clock;

   int         passed = 0;
   int         total  = 0;
   logic [7:0] stream [0:2047];
   int         ack_delay = 0;
   bit         ack_rand  = 1'b0;
   int         gen       = 0;

   // Memory model state, written only by the responder process below
   logic [7:0]    img_data [0:CAP-1];
   int            img_gen  [0:CAP-1];
   int            wr_count = 0, seq_err = 0, stab_err = 0, ready_err = 0;
   int            wcnt = 0, cur_delay = 0, mon_gen = -1, exp_addr = 0;
   logic [AW-1:0] hold_addr = '0;
   logic [7:0]    hold_d    = '0;

   always @(negedge clock) begin
      if (reset && mem_req) begin
         if (wcnt == 0) begin
            hold_addr = mem_address;
            hold_d    = mem_d;
            cur_delay = ack_rand ? int'($urandom_range(0, ack_delay)) : ack_delay;
         end else if (mem_address !== hold_addr || mem_d !== hold_d) begin
            stab_err++;
         end
         if (dl_ready !== 1'b0) ready_err++;
         if (wcnt >= cur_delay) begin
            mem_ack = 1'b1;
            if (gen != mon_gen) begin
               mon_gen  = gen;
               exp_addr = 0;
            end
            if (int'(mem_address) != exp_addr) seq_err++;
            exp_addr++;
            img_data[mem_address] = mem_d;
            img_gen[mem_address]  = gen;
            wr_count++;
            wcnt = 0;
         end else begin
            mem_ack = 1'b0;
            wcnt++;
         end
      end else begin
         mem_ack = 1'b0;
         wcnt    = 0;
      end
   end

   // Expected image: first k stream bytes, then 8'hFF to capacity, every cell from this stream
   function automatic int image_errors(input int k);
      int bad = 0;
      for (int a = 0; a < CAP; a++) begin
         logic [7:0] e;
         e = (a < k) ? stream[a] : 8'hFF;
         if (img_gen[a] != gen || img_data[a] !== e) bad++;
      end
      return bad;
   endfunction

   function automatic logic [7:0] model_sum(input int k);
      int s = 0;
      for (int i = 0; i < k; i++) s += int'(stream[i]);
`ifdef ROM_LOADER_CHECKSUM_EN
      return 8'(s);
`else
      return 8'h00;
`endif
   endfunction

   task automatic fill_random(input int n);
      for (int i = 0; i < n; i++) stream[i] = 8'($urandom);
   endtask

   task automatic pulse_start();
      @(negedge clock); dl_start = 1'b1;
      @(negedge clock); dl_start = 1'b0;
   endtask

   task automatic pulse_end();
      @(negedge clock); dl_end = 1'b1;
      @(negedge clock); dl_end = 1'b0;
   endtask

   task automatic send_bytes(input int n, input bit end_last, input bit gaps);
      int i = 0;
      int guard = 0;
      while (i < n && guard < 30000) begin
         @(negedge clock);
         guard++;
         dl_end = 1'b0;
         if (gaps && $urandom_range(0, 3) == 0) begin
            dl_valid = 1'b0;
         end else begin
            dl_valid = 1'b1;
            dl_data  = stream[i];
            if (dl_ready) begin
               if (end_last && i == n - 1) dl_end = 1'b1;
               i++;
            end
         end
      end
      @(negedge clock);
      dl_valid = 1'b0;
      dl_end   = 1'b0;
      total++;
      if (i !== n) $display("FAIL send_accept got %0d bytes want %0d", i, n); else passed++;
   endtask

   task automatic wait_done(input int bound, input string tag);
      int c = 0;
      while (done !== 1'b1 && c < bound) begin
         @(negedge clock);
         c++;
      end
      total++;
      if (done !== 1'b1) $display("FAIL %s_done got %b want 1", tag, done); else passed++;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clock);
      total++;
      if ({mem_req, busy, done, overflow, dl_ready} !== 5'b0)
         $display("FAIL reset_flags got %b want 00000", {mem_req, busy, done, overflow, dl_ready});
      else passed++;
      total++;
      if (size !== '0) $display("FAIL reset_size got %0d want 0", size); else passed++;
      total++;
      if (mem_address !== '0 || mem_d !== 8'h00)
         $display("FAIL reset_bus got %h/%h want 000/00", mem_address, mem_d);
      else passed++;
      total++;
      if (checksum !== 8'h00) $display("FAIL reset_checksum got %h want 00", checksum); else passed++;
      reset = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_basic();
      int base;
      gen++;
      ack_delay = 0; ack_rand = 1'b0;
      for (int i = 0; i < 4; i++) stream[i] = 8'(i + 1);
      base = wr_count;
      pulse_start();
      send_bytes(4, 1'b0, 1'b0);
      pulse_end();
      wait_done(5000, "basic");
      total++;
      if (image_errors(4) !== 0) $display("FAIL basic_image got %0d bad cells want 0", image_errors(4)); else passed++;
      total++;
      if (size !== 11'd4) $display("FAIL basic_size got %0d want 4", size); else passed++;
      total++;
      if (wr_count - base !== CAP) $display("FAIL basic_writes got %0d want %0d", wr_count - base, CAP); else passed++;
      total++;
      if ({busy, overflow} !== 2'b00) $display("FAIL basic_flags got %b want 00", {busy, overflow}); else passed++;
      total++;
`ifdef ROM_LOADER_CHECKSUM_EN
      if (checksum !== 8'h0A) $display("FAIL basic_checksum got %h want 0a", checksum); else passed++;
`else
      if (checksum !== 8'h00) $display("FAIL basic_checksum got %h want 00", checksum); else passed++;
`endif
   endtask

   task automatic test_slow_ack();
      int n;
      gen++;
      n = int'($urandom_range(20, 60));
      fill_random(n);
      ack_delay = 5; ack_rand = 1'b0;
      pulse_start();
      send_bytes(n, 1'b0, 1'b0);
      pulse_end();
      wait_done(20000, "slow");
      total++;
      if (image_errors(n) !== 0) $display("FAIL slow_image got %0d bad cells want 0", image_errors(n)); else passed++;
      total++;
      if (size !== 11'(n)) $display("FAIL slow_size got %0d want %0d", size, n); else passed++;
      total++;
      if (stab_err !== 0) $display("FAIL slow_stable got %0d changes want 0", stab_err); else passed++;
      total++;
      if (ready_err !== 0) $display("FAIL slow_ready got %0d want 0", ready_err); else passed++;
   endtask

   task automatic test_exact_full();
      int base;
      gen++;
      fill_random(CAP);
      ack_delay = 2; ack_rand = 1'b1;
      base = wr_count;
      pulse_start();
      send_bytes(CAP, 1'b0, 1'b0);
      pulse_end();
      wait_done(20000, "full");
      total++;
      if (wr_count - base !== CAP) $display("FAIL full_writes got %0d want %0d", wr_count - base, CAP); else passed++;
      total++;
      if (size !== 11'd1024 || overflow !== 1'b0)
         $display("FAIL full_size got %0d/%b want 1024/0", size, overflow);
      else passed++;
      total++;
      if (image_errors(CAP) !== 0) $display("FAIL full_image got %0d bad cells want 0", image_errors(CAP)); else passed++;
   endtask

   task automatic test_overflow();
      int base;
      gen++;
      fill_random(CAP + 2);
      ack_delay = 1; ack_rand = 1'b1;
      base = wr_count;
      pulse_start();
      send_bytes(CAP + 2, 1'b0, 1'b0);
      pulse_end();
      wait_done(20000, "ovf");
      total++;
      if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow); else passed++;
      total++;
      if (size !== 11'd1024) $display("FAIL ovf_size got %0d want 1024", size); else passed++;
      total++;
      if (wr_count - base !== CAP) $display("FAIL ovf_writes got %0d want %0d", wr_count - base, CAP); else passed++;
      total++;
      if (checksum !== model_sum(CAP)) $display("FAIL ovf_checksum got %h want %h", checksum, model_sum(CAP)); else passed++;
   endtask

   task automatic test_end_with_last();
      int n;
      gen++;
      n = int'($urandom_range(5, 30));
      fill_random(n);
      ack_delay = 3; ack_rand = 1'b1;
      pulse_start();
      total++;
      if ({overflow, done, busy} !== 3'b001 || size !== '0)
         $display("FAIL eol_clear got ovf/done/busy %b size %0d want 001 size 0", {overflow, done, busy}, size);
      else passed++;
      send_bytes(n, 1'b1, 1'b1);
      wait_done(20000, "eol");
      total++;
      if (image_errors(n) !== 0) $display("FAIL eol_image got %0d bad cells want 0", image_errors(n)); else passed++;
      total++;
      if (size !== 11'(n)) $display("FAIL eol_size got %0d want %0d", size, n); else passed++;
      total++;
      if (checksum !== model_sum(n)) $display("FAIL eol_checksum got %h want %h", checksum, model_sum(n)); else passed++;
   endtask

   task automatic test_restart_in_pad();
      int base;
      int c;
      int n2;
      gen++;
      fill_random(3);
      ack_delay = 3; ack_rand = 1'b0;
      pulse_start();
      send_bytes(3, 1'b0, 1'b0);
      pulse_end();
      c = 0;
      while (!(mem_req === 1'b1 && mem_address >= 10'd5) && c < 500) begin
         @(negedge clock);
         c++;
      end
      total++;
      if (!(mem_req === 1'b1 && mem_d === 8'hFF))
         $display("FAIL rst_pad_reach got req %b data %h want 1/ff", mem_req, mem_d);
      else passed++;
      base = wr_count;
      dl_start = 1'b1;
      @(negedge clock);
      dl_start = 1'b0;
      c = 0;
      while (dl_ready !== 1'b1 && c < 50) begin
         @(negedge clock);
         c++;
      end
      total++;
      if (dl_ready !== 1'b1) $display("FAIL rst_pad_recv got ready %b want 1", dl_ready); else passed++;
      total++;
      if (wr_count - base !== 1) $display("FAIL rst_pad_complete got %0d writes want 1", wr_count - base); else passed++;
      total++;
      if (size !== '0 || overflow !== 1'b0 || busy !== 1'b1)
         $display("FAIL rst_pad_clear got size %0d ovf %b busy %b want 0/0/1", size, overflow, busy);
      else passed++;
      gen++;
      n2 = int'($urandom_range(10, 40));
      fill_random(n2);
      ack_delay = 0;
      send_bytes(n2, 1'b1, 1'b0);
      wait_done(10000, "rst_pad");
      total++;
      if (image_errors(n2) !== 0) $display("FAIL rst_pad_image got %0d bad cells want 0", image_errors(n2)); else passed++;
      total++;
      if (size !== 11'(n2)) $display("FAIL rst_pad_size got %0d want %0d", size, n2); else passed++;
      total++;
      if (seq_err !== 0) $display("FAIL seq_addr got %0d out-of-order writes want 0", seq_err); else passed++;
   endtask

   task automatic test_reset_mid_write();
      gen++;
      ack_delay = 50; ack_rand = 1'b0;
      pulse_start();
      @(negedge clock);
      dl_valid = 1'b1;
      dl_data  = 8'h5A;
      @(negedge clock);
      dl_valid = 1'b0;
      total++;
      if (mem_req !== 1'b1 || mem_d !== 8'h5A)
         $display("FAIL rstw_req got req %b data %h want 1/5a", mem_req, mem_d);
      else passed++;
      reset = 1'b0;
      @(negedge clock);
      total++;
      if ({mem_req, busy, done, overflow, dl_ready} !== 5'b0)
         $display("FAIL rstw_flags got %b want 00000", {mem_req, busy, done, overflow, dl_ready});
      else passed++;
      total++;
      if (size !== '0 || mem_address !== '0 || mem_d !== 8'h00 || checksum !== 8'h00)
         $display("FAIL rstw_values got size %0d addr %h d %h cs %h want zeros", size, mem_address, mem_d, checksum);
      else passed++;
      reset = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_slow_ack();
      test_exact_full();
      test_overflow();
      test_end_with_last();
      test_restart_in_pad();
      test_reset_mid_write();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Write-side counterpart to the cartridge/BIOS ROM images.
- Accepts a byte stream from the host download channel (OSD/SPI data_io) and writes it sequentially into the RAM that backs cartridge ROM space.
- After the stream ends, pads the rest of the image with 8'hFF, which is the value unmapped cartridge reads return.
- Handshakes with a slow memory (SDRAM/BRAM arbiter) through req/ack and back-pressures the download channel.

Parameters:
- KB, 32, image capacity in KiB. Localparam AW = $clog2(KB*1024).
- PAD, 8'hFF, fill byte written from end-of-stream to capacity.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- dl_start  in  1  one-cycle pulse: begin new download
- dl_valid  in  1  dl_data valid
- dl_data  in  8  download byte
- dl_ready  out  1  loader can accept a byte this cycle
- dl_end  in  1  one-cycle pulse: stream finished
- mem_req  out  1  write request, held until ack
- mem_ack  in  1  write completed (sampled only while mem_req=1)
- mem_address  out  AW  write address
- mem_d  out  8  write data
- busy  out  1  download or padding in progress
- done  out  1  image complete; held until next dl_start
- size  out  AW+1  bytes received (excluding pad)
- overflow  out  1  sticky: byte arrived beyond capacity
- checksum  out  8  see Optional Feature

Behaviour:
- Reset (reset=0 at clock edge): state IDLE; all outputs 0; internal address counter 0; pending flags cleared.
- States: IDLE, RECV, WRITE, PAD, DONE.
- IDLE/DONE + dl_start -> RECV. Clear address, size, overflow and checksum; drop done; set busy. Ignore dl_valid/dl_end in IDLE and DONE.
- RECV:
  - dl_ready=1.
  - Byte accepted when dl_valid && dl_ready.
  - If address count < KB*1024: latch the byte into mem_d and the address into mem_address; next cycle mem_req=1 and state WRITE; dl_ready=0 during WRITE.
  - If count == KB*1024: discard the byte, set overflow, stay in RECV.
- WRITE:
  - mem_address and mem_d are stable while mem_req=1.
  - On mem_ack: drop mem_req the next cycle, increment address and size, return to RECV.
  - mem_ack may arrive in the first req cycle, giving a 2-cycle minimum byte-to-byte period.
- dl_end:
  - In RECV, go to PAD next cycle.
  - If dl_end coincides with an accepted byte, or arrives during WRITE, latch it as end_pending. After the current write is acked, go to PAD instead of RECV.
- PAD:
  - Write PAD at each address from the current address up to KB*1024-1, using the same req/ack rule.
  - After the final ack, or immediately if the address count already equals capacity, go to DONE.
  - size does not advance in PAD.
- DONE: busy=0, done=1, mem_req=0.
- dl_start during RECV: restart at once.
- dl_start during WRITE/PAD: latch it as start_pending. The outstanding request must complete (ack) before restart; no request is ever abandoned. Restart then behaves as IDLE + dl_start.
- Address counter is AW+1 bits wide; no wrap-around; mem_address is the low AW bits.
- reset=0 mid-operation: immediate return to IDLE, including dropping mem_req. The memory arbiter is reset by the same signal.

Optional Feature:
- Macro ROM_LOADER_CHECKSUM_EN.
- Defined: checksum is an 8-bit modulo-256 sum of every byte written during RECV/WRITE. Pad bytes and discarded overflow bytes are excluded. It updates on mem_ack, clears on dl_start, and is valid when done=1.
- Undefined: checksum is tied to 8'h00 and no adder is built.

Decomposition:
- Package rom_loader_pkg: state enum (IDLE, RECV, WRITE, PAD, DONE) and the default PAD constant 8'hFF.
- One natural sub-module, rom_loader_wr: holds the req/ack write port (address/data holding registers plus mem_req generation). It is used by both the RECV and PAD paths.

Test Plan:
- KB=1; dl_start; 4 bytes 01,02,03,04; mem_ack same cycle as req; dl_end -> writes 0..3 = 01..04, then addresses 4..1023 = FF; size=4; done=1; checksum=0A when the macro is defined.
- mem_ack delayed 5 cycles per write -> dl_ready=0 and address/data stable for the full req window; no bytes lost at dl_valid held high.
- Exactly 1024 bytes then dl_end -> no PAD writes; DONE next cycle after the last ack; size=1024; overflow=0.
- 1026 bytes -> the last 2 are discarded; overflow=1; size=1024; no write issued at a 1025th address.
- dl_end in the same cycle as the last accepted byte -> that byte is written, then PAD starts at the next address.
- dl_start during PAD with ack delayed 3 cycles -> the current pad write completes; size/overflow/address clear; the new stream starts at address 0. reset=0 mid-WRITE -> mem_req=0 next cycle; all outputs 0.
